// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: button/ball event inputs and the match status
// outputs that go to the paddle and ball blocks.
//   master : upstream side (debouncers, ball logic) driving events
//   slave  : pong_match_ctrl, driving match status
interface pong_match_ctrl_if;
  logic        start;
  logic        pause;
  logic        miss_left;
  logic        miss_right;
  logic        hit;
  logic        game_on;
  logic        paddle_rst;
  logic [31:0] ticks_per_px;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [1:0]  winner;
  logic        serve_dir;
  logic [2:0]  state;

  modport master (
    output start, pause, miss_left, miss_right, hit,
    input  game_on, paddle_rst, ticks_per_px, score_l, score_r, winner,
           serve_dir, state
  );

  modport slave (
    input  start, pause, miss_left, miss_right, hit,
    output game_on, paddle_rst, ticks_per_px, score_l, score_r, winner,
           serve_dir, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: keeps the score, sequences IDLE->SERVE->PLAY->POINT
// ->OVER, and drives game_on / paddle_rst / ticks_per_px to the paddles.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    pong_match_ctrl_if.slave (start, pause, miss_left, miss_right,
//          hit in; game_on, paddle_rst, ticks_per_px, score_l, score_r,
//          winner, serve_dir, state out; all outputs registered)
// Build option: define PONG_SPEEDUP_EN to shorten ticks_per_px on each hit.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_TICKS = 50_000_000,
  parameter int unsigned POINT_HOLD  = 25_000_000,
  parameter int unsigned BASE_TPP    = 100_000,
  parameter int unsigned MIN_TPP     = 20_000,
  parameter int unsigned TPP_STEP    = 10_000
) (
  input  logic               clk,
  input  logic               reset,
  pong_match_ctrl_if.slave   bus
);

  localparam int unsigned CNT_MAX = (SERVE_TICKS > POINT_HOLD) ? SERVE_TICKS : POINT_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, pause_q;
  logic               game_on_q, game_on_d;
  logic               paddle_rst_q, paddle_rst_d;
  logic [31:0]        tpp_q, tpp_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               start_edge, pause_edge, go_serve;

  assign start_edge = bus.start & ~start_q;
  assign pause_edge = bus.pause & ~pause_q;

`ifndef PONG_SPEEDUP_EN
  // Without speed-up, hit and the speed-up parameters have no effect.
  logic unused_cfg;
  assign unused_cfg = bus.hit ^ (|(32'(MIN_TPP) + 32'(TPP_STEP)));
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    game_on_d    = game_on_q;
    paddle_rst_d = paddle_rst_q;
    tpp_d        = tpp_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    go_serve     = 1'b0;

    case (state_q)
      IDLE: begin
        game_on_d    = 1'b0;
        paddle_rst_d = 1'b0;
        if (start_edge) go_serve = 1'b1;
      end
      SERVE: begin
        if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
          state_d      = PLAY;
          game_on_d    = 1'b1;
          paddle_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PLAY: begin
        if (bus.miss_left && bus.miss_right) begin
          // Simultaneous misses: nobody scores, replay the serve.
          go_serve = 1'b1;
        end else if (bus.miss_left || bus.miss_right) begin
          if (bus.miss_left) begin
            if (score_r_q < 4'(WIN_SCORE)) score_r_d = score_r_q + 4'd1;
            serve_dir_d = 1'b0;
          end else begin
            if (score_l_q < 4'(WIN_SCORE)) score_l_d = score_l_q + 4'd1;
            serve_dir_d = 1'b1;
          end
          state_d      = POINT;
          cnt_d        = '0;
          game_on_d    = 1'b0;
          paddle_rst_d = 1'b0;
        end else if (pause_edge) begin
          state_d   = PAUSED;
          game_on_d = 1'b0;
        end else if (bus.hit) begin
`ifdef PONG_SPEEDUP_EN
          // Saturate at MIN_TPP without wrapping below zero.
          if (tpp_q >= 32'(MIN_TPP) + 32'(TPP_STEP)) tpp_d = tpp_q - 32'(TPP_STEP);
          else                                       tpp_d = 32'(MIN_TPP);
`endif
        end
      end
      PAUSED: begin
        if (pause_edge) begin
          state_d   = PLAY;
          game_on_d = 1'b1;
        end
      end
      POINT: begin
        if (cnt_q == CNT_W'(POINT_HOLD - 1)) begin
          if (score_l_q == 4'(WIN_SCORE)) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else if (score_r_q == 4'(WIN_SCORE)) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            go_serve = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OVER: begin
        if (start_edge) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
          go_serve  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        game_on_d    = 1'b0;
        paddle_rst_d = 1'b0;
      end
    endcase

    // Every SERVE entry restarts the hold counter and the base speed.
    if (go_serve) begin
      state_d      = SERVE;
      cnt_d        = '0;
      tpp_d        = 32'(BASE_TPP);
      game_on_d    = 1'b0;
      paddle_rst_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      game_on_q    <= 1'b0;
      paddle_rst_q <= 1'b0;
      tpp_q        <= 32'(BASE_TPP);
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= bus.start;
      pause_q      <= bus.pause;
      game_on_q    <= game_on_d;
      paddle_rst_q <= paddle_rst_d;
      tpp_q        <= tpp_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.game_on      = game_on_q;
  assign bus.paddle_rst   = paddle_rst_q;
  assign bus.ticks_per_px = tpp_q;
  assign bus.score_l      = score_l_q;
  assign bus.score_r      = score_r_q;
  assign bus.winner       = winner_q;
  assign bus.serve_dir    = serve_dir_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a phase/timer match model predicts
// the outputs after each clock; a monitor compares them one cycle later.
module tb_pong_match_ctrl;
  localparam int WIN  = 2;
  localparam int ST   = 4;
  localparam int PH   = 3;
  localparam int BASE = 10;
  localparam int MINT = 4;
  localparam int STEP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_match_ctrl_if bus();

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_HOLD(PH),
    .BASE_TPP(BASE), .MIN_TPP(MINT), .TPP_STEP(STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int state;
    bit game_on;
    bit prst;
    bit chk_prst;
    int tpp;
    int sl;
    int sr;
    int winner;
    bit dir;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Match model: phase 0..5 = idle, serve, play, paused, point, over.
  int m_phase, m_left, m_sl, m_sr, m_win, m_tpp;
  bit m_dir, m_go, m_prst, m_ps, m_pp;

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0; m_win = 0; m_tpp = BASE;
    m_dir = 0; m_go = 0; m_prst = 0; m_ps = 0; m_pp = 0;
  endfunction

  function automatic void enter_serve();
    m_phase = 1; m_left = ST; m_tpp = BASE; m_go = 0; m_prst = 0;
  endfunction

  function automatic void model_step(bit s, bit p, bit ml, bit mr, bit h);
    bit se, pe;
    se = s && !m_ps;
    pe = p && !m_pp;
    case (m_phase)
      0: if (se) enter_serve();
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = 2; m_go = 1; m_prst = 1; end
      end
      2: begin
        if (ml && mr) enter_serve();
        else if (ml || mr) begin
          if (ml) begin m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 0; end
          else    begin m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1; end
          m_phase = 4; m_left = PH; m_go = 0;
        end else if (pe) begin
          m_phase = 3; m_go = 0;
        end else if (h) begin
`ifdef PONG_SPEEDUP_EN
          m_tpp = (m_tpp - STEP < MINT) ? MINT : m_tpp - STEP;
`endif
        end
      end
      3: if (pe) begin m_phase = 2; m_go = 1; end
      4: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_sl == WIN)      begin m_phase = 5; m_win = 1; end
          else if (m_sr == WIN) begin m_phase = 5; m_win = 2; end
          else enter_serve();
        end
      end
      5: if (se) begin m_sl = 0; m_sr = 0; m_win = 0; enter_serve(); end
      default: m_phase = 0;
    endcase
    m_ps = s;
    m_pp = p;
  endfunction

  task automatic drive(input bit s, input bit p, input bit ml, input bit mr, input bit h);
    exp_t e;
    @(negedge clk);
    bus.start = s; bus.pause = p; bus.miss_left = ml; bus.miss_right = mr; bus.hit = h;
    model_step(s, p, ml, mr, h);
    e.state = m_phase; e.game_on = m_go; e.prst = m_prst;
    e.chk_prst = (m_phase <= 3); e.tpp = m_tpp; e.sl = m_sl; e.sr = m_sr;
    e.winner = m_win; e.dir = m_dir;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (bus.state != 3'd0 || bus.game_on !== 1'b0 || bus.paddle_rst !== 1'b0 ||
        bus.ticks_per_px != 32'(BASE) || bus.score_l != 4'd0 || bus.score_r != 4'd0 ||
        bus.winner != 2'b00 || bus.serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL %s: got state=%0d game_on=%b paddle_rst=%b tpp=%0d sl=%0d sr=%0d winner=%0d dir=%b, required 0 0 0 %0d 0 0 0 0",
               name, bus.state, bus.game_on, bus.paddle_rst, bus.ticks_per_px,
               bus.score_l, bus.score_r, bus.winner, bus.serve_dir, BASE);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.start = 0; bus.pause = 0; bus.miss_left = 0; bus.miss_right = 0; bus.hit = 0;
    #1;
    check_reset("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.state != 3'(e.state) || bus.game_on !== e.game_on ||
            (e.chk_prst && bus.paddle_rst !== e.prst) ||
            bus.ticks_per_px != 32'(e.tpp) || bus.score_l != 4'(e.sl) ||
            bus.score_r != 4'(e.sr) || bus.winner != 2'(e.winner) ||
            bus.serve_dir !== e.dir) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got state=%0d game_on=%b paddle_rst=%b tpp=%0d sl=%0d sr=%0d winner=%0d dir=%b; required state=%0d game_on=%b paddle_rst=%b(chk %b) tpp=%0d sl=%0d sr=%0d winner=%0d dir=%b",
                   $time, bus.state, bus.game_on, bus.paddle_rst, bus.ticks_per_px,
                   bus.score_l, bus.score_r, bus.winner, bus.serve_dir,
                   e.state, e.game_on, e.prst, e.chk_prst, e.tpp, e.sl, e.sr, e.winner, e.dir);
        end
      end
    end
  end

  initial begin : stim
    bit sl_lvl, pl_lvl;
    bus.start = 0; bus.pause = 0; bus.miss_left = 0; bus.miss_right = 0; bus.hit = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    check_reset("power_on_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Start, serve hold, then play.
    drive(1, 0, 0, 0, 0);
    idle(4);
    // Three hits: speed-up saturates at the floor when enabled.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    // Right misses until left wins, then restart from OVER.
    drive(0, 0, 0, 1, 0);
    idle(3);
    idle(4);
    drive(0, 0, 0, 1, 0);
    idle(4);
    drive(1, 0, 0, 0, 0);
    idle(4);
    // Simultaneous misses replay the serve.
    drive(0, 0, 1, 1, 0);
    idle(4);
    // Pause, ignored miss, resume.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // Start edges outside IDLE/OVER are ignored.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    sl_lvl = 0;
    pl_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        async_reset();
        sl_lvl = 0;
        pl_lvl = 0;
      end
      if ($urandom_range(0, 7) == 0)  sl_lvl = ~sl_lvl;
      if ($urandom_range(0, 14) == 0) pl_lvl = ~pl_lvl;
      drive(sl_lvl, pl_lvl, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0);
    end

    repeat (5) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
